mem_mmio_unit: RTL and testbench

//  Memory subsystem that sits directly downstream of the multicycle MIPS core.
//  It consumes the core's adr/writedata/memwrite and returns readdata.
//  It holds a unified instruction/data RAM plus a small MMIO page with an LED

---
 rtl/mem_mmio_unit_if.sv | 31 +++
 rtl/mem_mmio_unit.sv | 169 ++++++++++++++++
 tb/tb_mem_mmio_unit.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_mmio_unit_if.sv
// rtl/mem_mmio_unit_if.sv - core memory bus and TX byte stream between the core side and mem_mmio_unit
// master drives address/store/ready; slave returns read data and the TX stream.
interface mem_mmio_unit_if;
  logic [31:0] adr;
  logic [31:0] writedata;
  logic        memwrite;
  logic [31:0] readdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    output adr,
    output writedata,
    output memwrite,
    output tx_ready,
    input  readdata,
    input  tx_data,
    input  tx_valid
  );

  modport slave (
    input  adr,
    input  writedata,
    input  memwrite,
    input  tx_ready,
    output readdata,
    output tx_data,
    output tx_valid
  );
endinterface

// File: rtl/mem_mmio_unit.sv
// rtl/mem_mmio_unit.sv - unified RAM plus MMIO page (LED, TX byte FIFO, compare timer) for the multicycle core
// Reads are combinational and stores commit at the next posedge; the core never stalls.
module mem_mmio_unit #(
  parameter int MEM_WORDS  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  mem_mmio_unit_if.slave   bus,
  output logic [7:0]       led,
  output logic             timer_irq
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FIFO_FULL_CNT = (PW+1)'(FIFO_DEPTH);

  localparam logic [5:0] OFF_LED    = 6'h00;
  localparam logic [5:0] OFF_TXDATA = 6'h01;
  localparam logic [5:0] OFF_STATUS = 6'h02;
  localparam logic [5:0] OFF_TCNT   = 6'h03;
  localparam logic [5:0] OFF_TCMP   = 6'h04;

  logic [31:0]   mem_q [MEM_WORDS];
  logic [7:0]    fifo_q [FIFO_DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [7:0]    led_q, led_d;
  logic          ovf_q, ovf_d;
  logic          tflag_q, tflag_d;
  logic [31:0]   tcnt_q, tcnt_d;
  logic [31:0]   tcmp_q, tcmp_d;

  logic          is_mmio;
  logic [5:0]    reg_sel;
  logic [AW-1:0] ram_idx;
  logic          wr_ram, wr_led, wr_txdata, wr_status, wr_tcnt, wr_tcmp;
  logic          fifo_empty, fifo_full;
  logic          pop, push_ok;
  logic          tcnt_match;
  logic          unused_adr;

  assign is_mmio    = (bus.adr[31:16] == 16'hFFFF);
  assign reg_sel    = bus.adr[7:2];
  assign ram_idx    = bus.adr[AW+1:2];
  assign unused_adr = ^{bus.adr[15:8], bus.adr[1:0]};

  assign wr_ram    = bus.memwrite & ~is_mmio;
  assign wr_led    = bus.memwrite & is_mmio & (reg_sel == OFF_LED);
  assign wr_txdata = bus.memwrite & is_mmio & (reg_sel == OFF_TXDATA);
  assign wr_status = bus.memwrite & is_mmio & (reg_sel == OFF_STATUS);
  assign wr_tcnt   = bus.memwrite & is_mmio & (reg_sel == OFF_TCNT);
  assign wr_tcmp   = bus.memwrite & is_mmio & (reg_sel == OFF_TCMP);

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FIFO_FULL_CNT);
  assign pop        = ~fifo_empty & bus.tx_ready;
  // A push into a full FIFO still lands if the head leaves on the same edge.
  assign push_ok    = wr_txdata & (~fifo_full | pop);

  assign tcnt_match = (tcmp_q != 32'd0) && (tcnt_q == tcmp_q);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    led_d    = led_q;
    ovf_d    = ovf_q;
    tflag_d  = tflag_q;
    tcnt_d   = tcnt_q + 32'd1;
    tcmp_d   = tcmp_q;

    if (wr_led) begin
      led_d = bus.writedata[7:0];
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase

    if (wr_status && bus.writedata[2]) begin
      ovf_d = 1'b0;
    end
    if (wr_txdata && !push_ok) begin
      ovf_d = 1'b1;
    end

    if (wr_tcmp) begin
      tcmp_d = bus.writedata;
    end

    // A TCNT store suppresses both the increment and any match this cycle.
    if (wr_tcnt) begin
      tcnt_d = bus.writedata;
    end else if (tcnt_match) begin
      tcnt_d = 32'd0;
    end

    if (wr_status && bus.writedata[3]) begin
      tflag_d = 1'b0;
    end
    if (tcnt_match && !wr_tcnt) begin
      tflag_d = 1'b1;
    end
  end

  // Storage arrays carry no reset: RAM survives reset and FIFO slots are dead while empty.
  always_ff @(posedge clk) begin
    if (wr_ram) begin
      mem_q[ram_idx] <= bus.writedata;
    end
    if (reset && push_ok) begin
      fifo_q[wr_ptr_q] <= bus.writedata[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      led_q    <= 8'd0;
      ovf_q    <= 1'b0;
      tflag_q  <= 1'b0;
      tcnt_q   <= 32'd0;
      tcmp_q   <= 32'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      led_q    <= led_d;
      ovf_q    <= ovf_d;
      tflag_q  <= tflag_d;
      tcnt_q   <= tcnt_d;
      tcmp_q   <= tcmp_d;
    end
  end

  always_comb begin
    bus.readdata = 32'd0;
    if (is_mmio) begin
      case (reg_sel)
        OFF_LED:    bus.readdata = {24'd0, led_q};
        OFF_STATUS: bus.readdata = {28'd0, tflag_q, ovf_q, fifo_full, fifo_empty};
        OFF_TCNT:   bus.readdata = tcnt_q;
        OFF_TCMP:   bus.readdata = tcmp_q;
        default:    bus.readdata = 32'd0;
      endcase
    end else begin
      bus.readdata = mem_q[ram_idx];
    end
  end

  assign bus.tx_data  = fifo_q[rd_ptr_q];
  assign bus.tx_valid = ~fifo_empty;
  assign led          = led_q;
  assign timer_irq    = tflag_q;

endmodule

// File: tb/tb_mem_mmio_unit.sv
// tb/tb_mem_mmio_unit.sv - scoreboard bench for mem_mmio_unit
// Stimulus queues expected values; a negedge monitor pops and compares them.
module tb_mem_mmio_unit;

  localparam int MEM_WORDS = 64;

  localparam logic [31:0] A_LED    = 32'hFFFF_0000;
  localparam logic [31:0] A_TXDATA = 32'hFFFF_0004;
  localparam logic [31:0] A_STATUS = 32'hFFFF_0008;
  localparam logic [31:0] A_TCNT   = 32'hFFFF_000C;
  localparam logic [31:0] A_TCMP   = 32'hFFFF_0010;

  localparam int K_RD   = 0;
  localparam int K_LED  = 1;
  localparam int K_TXV  = 2;
  localparam int K_IRQ  = 3;
  localparam int K_TXD  = 4;
  localparam int K_QEMP = 5;

  typedef struct {
    int          kind;
    string       name;
    logic [31:0] exp;
  } chk_t;

  logic       clk;
  logic       reset;
  logic [7:0] led;
  logic       timer_irq;

  mem_mmio_unit_if bus ();

  mem_mmio_unit #(.MEM_WORDS(MEM_WORDS), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .led       (led),
    .timer_irq (timer_irq)
  );

  chk_t       exp_q[$];
  logic [7:0] tx_exp_q[$];
  int         checks   = 0;
  int         failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    chk_t        c;
    logic [31:0] got;
    logic [7:0]  eb;
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front();
      case (c.kind)
        K_RD:    got = bus.readdata;
        K_LED:   got = {24'd0, led};
        K_TXV:   got = {31'd0, bus.tx_valid};
        K_IRQ:   got = {31'd0, timer_irq};
        K_TXD:   got = {24'd0, bus.tx_data};
        default: got = tx_exp_q.size();
      endcase
      checks++;
      if (got !== c.exp) begin
        failures++;
        $display("FAIL %s got=0x%08h exp=0x%08h", c.name, got, c.exp);
      end
    end
    if (reset && bus.tx_valid && bus.tx_ready) begin
      checks++;
      if (tx_exp_q.size() == 0) begin
        failures++;
        $display("FAIL tx_unexpected got=0x%02h exp=none", bus.tx_data);
      end else begin
        eb = tx_exp_q.pop_front();
        if (bus.tx_data !== eb) begin
          failures++;
          $display("FAIL tx_byte got=0x%02h exp=0x%02h", bus.tx_data, eb);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input int kind, input string name, input logic [31:0] exp);
    chk_t c;
    c.kind = kind;
    c.name = name;
    c.exp  = exp;
    exp_q.push_back(c);
  endtask

  task automatic set_wr(input logic [31:0] a, input logic [31:0] d);
    bus.adr       = a;
    bus.writedata = d;
    bus.memwrite  = 1'b1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    set_wr(a, d);
    step();
    bus.memwrite = 1'b0;
  endtask

  initial begin
    reset         = 1'b0;
    bus.adr       = 32'd0;
    bus.writedata = 32'd0;
    bus.memwrite  = 1'b0;
    bus.tx_ready  = 1'b0;
    step();
    step();
    reset = 1'b1;

    bus.adr = A_TCNT;
    chk(K_RD, "rst_tcnt", 32'd0);
    chk(K_LED, "rst_led", 32'd0);
    chk(K_TXV, "rst_txv", 32'd0);
    chk(K_IRQ, "rst_irq", 32'd0);
    step();
    bus.adr = A_STATUS;
    chk(K_RD, "rst_status", 32'h1);
    step();

    // RAM write, readback and aliasing
    wr(32'h20, 32'hDEAD_BEEF);
    wr(32'h24, 32'h1234_5678);
    bus.adr = 32'h20;
    chk(K_RD, "ram_rd", 32'hDEAD_BEEF);
    step();
    bus.adr = 32'h20 + 4 * MEM_WORDS;
    chk(K_RD, "ram_alias", 32'hDEAD_BEEF);
    step();
    bus.adr = 32'h8000_0024;
    chk(K_RD, "ram_alias_hi", 32'h1234_5678);
    step();
    wr(32'hFFFF_0020, 32'h1111_1111);
    bus.adr = 32'hFFFF_0020;
    chk(K_RD, "mmio_unmapped", 32'd0);
    step();
    bus.adr = 32'h20;
    chk(K_RD, "ram_not_hit_by_mmio", 32'hDEAD_BEEF);
    step();

    // LED register
    wr(A_LED, 32'h1A5);
    set_wr(A_LED, 32'h3C);
    chk(K_LED, "led_a5", 32'hA5);
    chk(K_RD, "led_rd_prewrite", 32'hA5);
    step();
    bus.memwrite = 1'b0;
    chk(K_RD, "led_rd_3c", 32'h3C);
    chk(K_LED, "led_3c", 32'h3C);
    step();

    // FIFO overflow then drain
    bus.tx_ready = 1'b0;
    for (int b = 8'h41; b <= 8'h45; b++) begin
      set_wr(A_TXDATA, 32'(b));
      if (b <= 8'h44) tx_exp_q.push_back(8'(b));
      step();
    end
    bus.memwrite = 1'b0;
    bus.adr = A_STATUS;
    chk(K_RD, "t3_status_full_ovf", 32'h6);
    chk(K_TXD, "t3_head", 32'h41);
    chk(K_TXV, "t3_txv", 32'h1);
    step();
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk(K_TXV, "t3_drained", 32'h0);
    chk(K_RD, "t3_status_ovf_empty", 32'h5);
    step();
    wr(A_STATUS, 32'h4);
    chk(K_RD, "t3_ovf_cleared", 32'h1);
    step();
    bus.adr = A_TXDATA;
    chk(K_RD, "txdata_rd0", 32'h0);
    step();

    // Push into full FIFO together with a pop
    bus.tx_ready = 1'b0;
    for (int b = 8'h50; b <= 8'h53; b++) begin
      set_wr(A_TXDATA, 32'(b));
      tx_exp_q.push_back(8'(b));
      step();
    end
    bus.tx_ready = 1'b1;
    set_wr(A_TXDATA, 32'h55);
    tx_exp_q.push_back(8'h55);
    step();
    bus.memwrite = 1'b0;
    bus.adr = A_STATUS;
    chk(K_RD, "t4_status_full_no_ovf", 32'h2);
    step();
    for (int i = 0; i < 4; i++) step();
    chk(K_TXV, "t4_drained", 32'h0);
    chk(K_RD, "t4_status_empty", 32'h1);
    step();

    // Push into empty FIFO while ready is high
    set_wr(A_TXDATA, 32'h66);
    tx_exp_q.push_back(8'h66);
    chk(K_TXV, "empty_push_txv0", 32'h0);
    step();
    bus.memwrite = 1'b0;
    chk(K_TXV, "empty_push_txv1", 32'h1);
    chk(K_TXD, "empty_push_head", 32'h66);
    step();
    chk(K_TXV, "empty_push_popped", 32'h0);
    step();

    // Reset with bytes queued, ovf set, LED and TCMP written
    bus.tx_ready = 1'b0;
    for (int b = 8'h71; b <= 8'h75; b++) begin
      wr(A_TXDATA, 32'(b));
    end
    wr(A_LED, 32'h5A);
    wr(A_TCMP, 32'h7);
    wr(32'h40, 32'hCAFE_F00D);
    bus.tx_ready = 1'b1;
    reset = 1'b0;
    step();
    reset = 1'b1;
    bus.adr = A_STATUS;
    chk(K_TXV, "t6_txv", 32'h0);
    chk(K_LED, "t6_led", 32'h0);
    chk(K_RD, "t6_status", 32'h1);
    step();
    bus.adr = 32'h40;
    chk(K_RD, "t6_ram40", 32'hCAFE_F00D);
    step();
    bus.adr = 32'h20;
    chk(K_RD, "t6_ram20", 32'hDEAD_BEEF);
    step();
    bus.tx_ready = 1'b0;

    // Timer compare, W1C and set-wins
    reset = 1'b0;
    step();
    reset = 1'b1;
    set_wr(A_TCMP, 32'h3);
    chk(K_RD, "t5_tcmp_rst", 32'h0);
    step();
    bus.memwrite = 1'b0;
    bus.adr = A_TCNT;
    chk(K_RD, "t5_cnt1", 32'h1);
    chk(K_IRQ, "t5_irq_c1", 32'h0);
    step();
    chk(K_RD, "t5_cnt2", 32'h2);
    step();
    chk(K_RD, "t5_cnt3", 32'h3);
    chk(K_IRQ, "t5_irq_c3", 32'h0);
    step();
    chk(K_RD, "t5_wrap0", 32'h0);
    chk(K_IRQ, "t5_irq_set", 32'h1);
    step();
    chk(K_RD, "t5_cnt1b", 32'h1);
    step();
    set_wr(A_STATUS, 32'h8);
    chk(K_IRQ, "t5_irq_before_clr", 32'h1);
    step();
    bus.memwrite = 1'b0;
    bus.adr = A_TCNT;
    chk(K_IRQ, "t5_irq_cleared", 32'h0);
    chk(K_RD, "t5_cnt3b", 32'h3);
    step();
    bus.adr = A_STATUS;
    chk(K_IRQ, "t5_irq_rematch", 32'h1);
    chk(K_RD, "t5_status_tflag", 32'h9);
    step();
    wr(A_STATUS, 32'h8);
    bus.adr = A_TCNT;
    chk(K_IRQ, "t5_irq_clr2", 32'h0);
    chk(K_RD, "t5_cnt2c", 32'h2);
    step();
    set_wr(A_STATUS, 32'h8);
    chk(K_IRQ, "t5_irq_pre_setwins", 32'h0);
    step();
    bus.memwrite = 1'b0;
    bus.adr = A_TCNT;
    chk(K_IRQ, "t5_set_wins", 32'h1);
    chk(K_RD, "t5_cnt0c", 32'h0);
    step();
    wr(A_TCNT, 32'h100);
    bus.adr = A_TCNT;
    chk(K_RD, "t5_tcnt_load", 32'h100);
    step();

    chk(K_QEMP, "tx_queue_empty", 32'h0);
    step();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
